bitstream_window_buffer: RTL

- Upstream neighbour of the Exp-Golomb decoder.
- Accepts 16-bit NAL payload words over a valid/ready handshake and holds them in a 48-bit MSB-aligned shift buffer.
- Presents a registered 16-bit bit window (BitStream_buffer_output) plus the combinational heading_one_pos for that window.
- Discards consumed bits by a variable length each cycle (e.g. exp_golomb_len) and supports byte alignment and flush between NAL units.

---
 rtl/bitstream_window_buffer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bitstream_window_buffer.sv
// Bitstream window buffer.
// Sits upstream of the Exp-Golomb decoder. It collects 16-bit NAL payload
// words into a 48-bit MSB-aligned shift buffer and presents the top 16 bits
// as the decode window. The decoder discards bits from the head each cycle
// by a variable length, or aligns to the next byte boundary.
module bitstream_window_buffer #(
    parameter int PC_W = 20
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [15:0]     word_in,
    input  logic            word_valid,
    output logic            word_ready,
    input  logic            consume_en,
    input  logic [4:0]      consume_len,
    input  logic            byte_align,
    input  logic            flush,
    output logic [15:0]     BitStream_buffer_output,
    output logic            window_valid,
    output logic [3:0]      heading_one_pos,
    output logic [PC_W-1:0] pc,
    output logic            underflow_err
);

    // The buffer width is tied to the 16-bit word and window sizes.
    localparam int BUF_W = 48;

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_next;
    logic [5:0]       cnt_q;
    logic [5:0]       cnt_next;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_next;
    logic             err_q;
    logic             err_next;

    logic             accept;
    logic [4:0]       drop;
    logic [2:0]       align_drop;
    logic [5:0]       cnt_after_drop;
    logic [BUF_W-1:0] buf_after_drop;
    logic [BUF_W-1:0] word_aligned;

    // A word can be taken only while it is guaranteed to fit, even if no
    // bits are dropped in the same cycle.
    assign word_ready = reset_n & ~flush & (cnt_q <= 6'd32);
    assign accept     = word_valid & word_ready;

    // Bits still needed to reach the next byte boundary of the stream.
    assign align_drop = 3'd0 - pc_q[2:0];

    // Resolve the drop request (flush > consume > align), then merge the
    // incoming word directly below the surviving valid bits.
    always_comb begin
        drop     = 5'd0;
        err_next = err_q;
        if (!flush) begin
            if (consume_en) begin
                if ((consume_len <= 5'd16) && ({1'b0, consume_len} <= cnt_q)) begin
                    drop = consume_len;
                end else begin
                    err_next = 1'b1;
                end
            end else if (byte_align) begin
                if ({3'd0, align_drop} <= cnt_q) begin
                    drop = {2'd0, align_drop};
                end else begin
                    err_next = 1'b1;
                end
            end
        end

        buf_after_drop = buf_q << drop;
        cnt_after_drop = cnt_q - {1'b0, drop};
        word_aligned   = {word_in, 32'd0} >> cnt_after_drop;

        if (flush) begin
            buf_next = '0;
            cnt_next = 6'd0;
            pc_next  = '0;
        end else begin
            buf_next = buf_after_drop;
            cnt_next = cnt_after_drop;
            pc_next  = pc_q + PC_W'(drop);
            if (accept) begin
                buf_next = buf_after_drop | word_aligned;
                cnt_next = cnt_after_drop + 6'd16;
            end
        end
    end

    // State registers; the underflow flag survives flush and clears only on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q <= '0;
            cnt_q <= 6'd0;
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            buf_q <= buf_next;
            cnt_q <= cnt_next;
            pc_q  <= pc_next;
            err_q <= err_next;
        end
    end

    assign BitStream_buffer_output = buf_q[BUF_W-1:BUF_W-16];
    assign window_valid            = (cnt_q >= 6'd16);
    assign pc                      = pc_q;
    assign underflow_err           = err_q;

    // Leading-zero count over the top byte of the window; 15 flags a prefix
    // longer than the decoder handles in one step.
    always_comb begin
        heading_one_pos = 4'd15;
        for (int i = 8; i <= 15; i++) begin
            if (BitStream_buffer_output[i]) begin
                heading_one_pos = 4'(15 - i);
            end
        end
    end

endmodule
